// File: rtl/machine_trap_control_n_if.sv
// Bundle between the decode/CSR side and the M-mode trap sequencer.
// The decode/CSR side uses the master modport and the sequencer uses the slave modport.
interface machine_trap_control_n_if #(
  parameter int unsigned NUM_LOCAL_IRQ = 4
);
  logic [4:0]               opcode_6_to_2_in;
  logic [2:0]               funct3_in;
  logic [6:0]               funct7_in;
  logic [4:0]               rs1_addr_in;
  logic [4:0]               rs2_addr_in;
  logic [4:0]               rd_addr_in;
  logic                     illegal_instr_in;
  logic                     misaligned_instr_in;
  logic                     misaligned_load_in;
  logic                     misaligned_store_in;
  logic                     e_irq_in;
  logic                     t_irq_in;
  logic                     s_irq_in;
  logic [NUM_LOCAL_IRQ-1:0] local_irq_in;
  logic                     mie_in;
  logic                     meie_in;
  logic                     mtie_in;
  logic                     msie_in;
  logic                     meip_in;
  logic                     mtip_in;
  logic                     msip_in;
  logic [NUM_LOCAL_IRQ-1:0] mlie_in;
  logic                     mtvec_mode_in;

  logic [1:0]               pc_src_out;
  logic                     flush_out;
  logic                     stall_out;
  logic                     instret_inc_out;
  logic                     set_epc_out;
  logic                     set_cause_out;
  logic                     mie_clear_out;
  logic                     mie_set_out;
  logic [4:0]               cause_out;
  logic                     i_or_e_out;
  logic [6:0]               trap_offset_out;
  logic                     misaligned_exception_out;
  logic                     trap_taken_out;

  modport master (
    output opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
           illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
           e_irq_in, t_irq_in, s_irq_in, local_irq_in, mie_in, meie_in, mtie_in, msie_in,
           meip_in, mtip_in, msip_in, mlie_in, mtvec_mode_in,
    input  pc_src_out, flush_out, stall_out, instret_inc_out, set_epc_out, set_cause_out,
           mie_clear_out, mie_set_out, cause_out, i_or_e_out, trap_offset_out,
           misaligned_exception_out, trap_taken_out
  );

  modport slave (
    input  opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
           illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
           e_irq_in, t_irq_in, s_irq_in, local_irq_in, mie_in, meie_in, mtie_in, msie_in,
           meip_in, mtip_in, msip_in, mlie_in, mtvec_mode_in,
    output pc_src_out, flush_out, stall_out, instret_inc_out, set_epc_out, set_cause_out,
           mie_clear_out, mie_set_out, cause_out, i_or_e_out, trap_offset_out,
           misaligned_exception_out, trap_taken_out
  );
endinterface

// File: rtl/machine_trap_control_n.sv
// M-mode trap/return sequencer: WFI sleep with optional timeout, fixed cause priority,
// vectored trap offset; drives PC source, flush/stall and mepc/mcause/MIE update strobes.
module machine_trap_control_n #(
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter int unsigned WFI_TIMEOUT   = 0,
  parameter int unsigned TO_W          = 16
) (
  input logic                     clk_in,
  input logic                     reset_n_in,
  machine_trap_control_n_if.slave bus
);

  typedef enum logic [4:0] {
    ST_RESET       = 5'b00001,
    ST_OPERATING   = 5'b00010,
    ST_TRAP_TAKEN  = 5'b00100,
    ST_TRAP_RETURN = 5'b01000,
    ST_WFI         = 5'b10000
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = (WFI_TIMEOUT == 0) ? '0 : TO_W'(WFI_TIMEOUT - 1);

  state_t                   state;
  state_t                   state_next;
  logic [TO_W-1:0]          wfi_count;
  logic                     sys_base;
  logic                     is_ecall;
  logic                     is_ebreak;
  logic                     is_mret;
  logic                     is_wfi;
  logic                     eip;
  logic                     tip;
  logic                     sip;
  logic [NUM_LOCAL_IRQ-1:0] lip;
  logic                     ip;
  logic                     exc;
  logic                     trap;
  logic                     timeout;
  logic [4:0]               cause_d;
  logic                     irq_d;
  logic                     found;

  assign sys_base  = (bus.opcode_6_to_2_in == 5'b11100) && (bus.rs1_addr_in == '0) &&
                     (bus.rd_addr_in == '0) && (bus.funct3_in == '0);
  assign is_ecall  = sys_base && (bus.funct7_in == 7'b0000000) && (bus.rs2_addr_in == 5'd0);
  assign is_ebreak = sys_base && (bus.funct7_in == 7'b0000000) && (bus.rs2_addr_in == 5'd1);
  assign is_mret   = sys_base && (bus.funct7_in == 7'b0011000) && (bus.rs2_addr_in == 5'd2);
  assign is_wfi    = sys_base && (bus.funct7_in == 7'b0001000) && (bus.rs2_addr_in == 5'd5);

  assign eip = bus.meie_in & (bus.e_irq_in | bus.meip_in);
  assign tip = bus.mtie_in & (bus.t_irq_in | bus.mtip_in);
  assign sip = bus.msie_in & (bus.s_irq_in | bus.msip_in);
  assign lip = bus.mlie_in & bus.local_irq_in;
  assign ip  = eip | tip | sip | (|lip);
  assign exc = bus.illegal_instr_in | bus.misaligned_instr_in |
               bus.misaligned_load_in | bus.misaligned_store_in;

  assign trap = ((state == ST_OPERATING) && ((bus.mie_in && ip) || exc || is_ecall || is_ebreak)) ||
                ((state == ST_WFI) && bus.mie_in && ip);
  assign bus.trap_taken_out = trap;

  assign timeout = (WFI_TIMEOUT != 0) && (wfi_count == TO_LAST);

  assign bus.trap_offset_out = (bus.mtvec_mode_in && bus.i_or_e_out) ? {bus.cause_out, 2'b00} : '0;

  // First match wins; interrupts only count while globally enabled.
  always_comb begin
    cause_d = '0;
    irq_d   = 1'b0;
    found   = 1'b0;
    if (bus.mie_in && eip) begin
      cause_d = 5'd11; irq_d = 1'b1;
    end else if (bus.mie_in && sip) begin
      cause_d = 5'd3;  irq_d = 1'b1;
    end else if (bus.mie_in && tip) begin
      cause_d = 5'd7;  irq_d = 1'b1;
    end else if (bus.mie_in && (|lip)) begin
      irq_d = 1'b1;
      for (int unsigned i = 0; i < NUM_LOCAL_IRQ; i++) begin
        if (lip[i] && !found) begin
          cause_d = 5'(16 + i);
          found   = 1'b1;
        end
      end
    end else if (bus.misaligned_instr_in) cause_d = 5'd0;
    else if (bus.illegal_instr_in)        cause_d = 5'd2;
    else if (is_ebreak)                   cause_d = 5'd3;
    else if (is_ecall)                    cause_d = 5'd11;
    else if (bus.misaligned_store_in)     cause_d = 5'd6;
    else if (bus.misaligned_load_in)      cause_d = 5'd4;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_RESET:       state_next = ST_OPERATING;
      ST_OPERATING: begin
        if (trap)         state_next = ST_TRAP_TAKEN;
        else if (is_mret) state_next = ST_TRAP_RETURN;
        else if (is_wfi)  state_next = ST_WFI;
      end
      ST_TRAP_TAKEN,
      ST_TRAP_RETURN: state_next = ST_OPERATING;
      ST_WFI: begin
        if (bus.mie_in && ip)  state_next = ST_TRAP_TAKEN;
        else if (ip || timeout) state_next = ST_OPERATING;
      end
      default:        state_next = ST_RESET;
    endcase
  end

  // {pc_src, flush, stall, instret, set_epc, set_cause, mie_clear, mie_set}
  function automatic logic [8:0] state_outputs(state_t s);
    unique case (s)
      ST_OPERATING:   return 9'b11_0_0_1_0_0_0_0;
      ST_TRAP_TAKEN:  return 9'b10_1_0_0_1_1_1_0;
      ST_TRAP_RETURN: return 9'b01_1_0_0_0_0_0_1;
      ST_WFI:         return 9'b11_0_1_0_0_0_0_0;
      default:        return 9'b00_1_0_0_0_0_0_0;
    endcase
  endfunction

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state                        <= ST_RESET;
      wfi_count                    <= '0;
      bus.cause_out                <= '0;
      bus.i_or_e_out               <= 1'b0;
      bus.misaligned_exception_out <= 1'b0;
      {bus.pc_src_out, bus.flush_out, bus.stall_out, bus.instret_inc_out, bus.set_epc_out,
       bus.set_cause_out, bus.mie_clear_out, bus.mie_set_out} <= state_outputs(ST_RESET);
    end else begin
      state                        <= state_next;
      bus.misaligned_exception_out <= bus.misaligned_instr_in | bus.misaligned_load_in |
                                      bus.misaligned_store_in;
      if (trap) begin
        bus.cause_out  <= cause_d;
        bus.i_or_e_out <= irq_d;
      end
      if (state != ST_WFI)       wfi_count <= '0;
      else if (wfi_count != '1)  wfi_count <= wfi_count + 1'b1;
      {bus.pc_src_out, bus.flush_out, bus.stall_out, bus.instret_inc_out, bus.set_epc_out,
       bus.set_cause_out, bus.mie_clear_out, bus.mie_set_out} <= state_outputs(state_next);
    end
  end

endmodule

// File: tb/tb_machine_trap_control_n.sv
// Bench for machine_trap_control_n: directed vector table, multi-cycle sequences,
// and randomized stimulus against a behavioural model.
module tb_machine_trap_control_n;
  localparam int unsigned NL = 4;
  localparam int unsigned TO = 8;

  localparam logic [8:0] O_BOOT  = 9'b00_1_0_0_0_0_0_0;
  localparam logic [8:0] O_RUN   = 9'b11_0_0_1_0_0_0_0;
  localparam logic [8:0] O_ENTER = 9'b10_1_0_0_1_1_1_0;
  localparam logic [8:0] O_RET   = 9'b01_1_0_0_0_0_0_1;
  localparam logic [8:0] O_SLEEP = 9'b11_0_1_0_0_0_0_0;

  typedef enum int {K_NONE, K_ADD, K_ECALL, K_EBREAK, K_MRET, K_WFI, K_NEAR} kind_t;
  typedef enum int {M_BOOT, M_RUN, M_ENTER, M_RET, M_SLEEP} mphase_t;

  typedef struct {
    string      name;
    kind_t      kind;
    logic [6:0] irq;    // {mie, meie, e_irq, mtie, mtip, msie, msip}
    logic [3:0] mlie;
    logic [3:0] lirq;
    logic [4:0] ex;     // {illegal, mis_instr, mis_load, mis_store, mtvec_mode}
    logic       exp_trap;
    logic [1:0] exp_pc;
    logic       exp_stall;
    logic [4:0] exp_cause;
    logic       exp_ie;
    logic [6:0] exp_off;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  machine_trap_control_n_if #(.NUM_LOCAL_IRQ(NL)) bus ();

  machine_trap_control_n #(.NUM_LOCAL_IRQ(NL), .WFI_TIMEOUT(TO), .TO_W(16)) dut (
    .clk_in(clk), .reset_n_in(rst_n), .bus(bus)
  );

  int      n_run = 0;
  int      n_fail = 0;
  kind_t   cur_kind = K_NONE;
  vec_t    tbl[$];
  mphase_t ph = M_BOOT;
  logic [4:0] m_cause = '0;
  logic    m_ie = 1'b0;
  logic    m_mis = 1'b0;
  int      m_sleep = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] dut_outs();
    return {bus.pc_src_out, bus.flush_out, bus.stall_out, bus.instret_inc_out, bus.set_epc_out,
            bus.set_cause_out, bus.mie_clear_out, bus.mie_set_out};
  endfunction

  task automatic set_instr(kind_t k);
    cur_kind = k;
    bus.opcode_6_to_2_in = 5'b11100;
    bus.funct3_in = 3'd0; bus.rs1_addr_in = 5'd0; bus.rd_addr_in = 5'd0;
    bus.funct7_in = 7'd0; bus.rs2_addr_in = 5'd0;
    case (k)
      K_NONE:   bus.opcode_6_to_2_in = 5'b00000;
      K_ADD:    begin bus.opcode_6_to_2_in = 5'b01100; bus.rs1_addr_in = 5'd1;
                      bus.rs2_addr_in = 5'd3; bus.rd_addr_in = 5'd2; end
      K_EBREAK: bus.rs2_addr_in = 5'd1;
      K_MRET:   begin bus.funct7_in = 7'b0011000; bus.rs2_addr_in = 5'd2; end
      K_WFI:    begin bus.funct7_in = 7'b0001000; bus.rs2_addr_in = 5'd5; end
      K_NEAR:   bus.rd_addr_in = 5'd1;
      default:  ;
    endcase
  endtask

  task automatic clear_inputs();
    set_instr(K_NONE);
    {bus.mie_in, bus.meie_in, bus.e_irq_in, bus.mtie_in, bus.mtip_in, bus.msie_in, bus.msip_in} = '0;
    bus.t_irq_in = 1'b0; bus.s_irq_in = 1'b0; bus.meip_in = 1'b0;
    bus.mlie_in = '0; bus.local_irq_in = '0;
    {bus.illegal_instr_in, bus.misaligned_instr_in, bus.misaligned_load_in,
     bus.misaligned_store_in, bus.mtvec_mode_in} = '0;
  endtask

  task automatic add_vec(string n, kind_t k, logic [6:0] irq, logic [3:0] mlie, logic [3:0] lirq,
                         logic [4:0] ex, logic t, logic [1:0] pc, logic st, logic [4:0] c,
                         logic ie, logic [6:0] off);
    vec_t v;
    v.name = n; v.kind = k; v.irq = irq; v.mlie = mlie; v.lirq = lirq; v.ex = ex;
    v.exp_trap = t; v.exp_pc = pc; v.exp_stall = st; v.exp_cause = c; v.exp_ie = ie; v.exp_off = off;
    tbl.push_back(v);
  endtask

  task automatic apply_vec(vec_t v);
    set_instr(v.kind);
    {bus.mie_in, bus.meie_in, bus.e_irq_in, bus.mtie_in, bus.mtip_in, bus.msie_in, bus.msip_in} = v.irq;
    bus.mlie_in = v.mlie; bus.local_irq_in = v.lirq;
    {bus.illegal_instr_in, bus.misaligned_instr_in, bus.misaligned_load_in,
     bus.misaligned_store_in, bus.mtvec_mode_in} = v.ex;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; clear_inputs();
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_eip(); return bus.meie_in && (bus.e_irq_in || bus.meip_in); endfunction
  function automatic bit m_tip(); return bus.mtie_in && (bus.t_irq_in || bus.mtip_in); endfunction
  function automatic bit m_sip(); return bus.msie_in && (bus.s_irq_in || bus.msip_in); endfunction
  function automatic bit m_ip();
    return m_eip() || m_tip() || m_sip() || ((bus.mlie_in & bus.local_irq_in) != 0);
  endfunction
  function automatic bit m_exc();
    return bus.illegal_instr_in || bus.misaligned_instr_in || bus.misaligned_load_in ||
           bus.misaligned_store_in;
  endfunction
  function automatic bit m_trap();
    if (ph == M_RUN)   return (bus.mie_in && m_ip()) || m_exc() || cur_kind == K_ECALL || cur_kind == K_EBREAK;
    if (ph == M_SLEEP) return bus.mie_in && m_ip();
    return 1'b0;
  endfunction

  task automatic m_cause_calc(output logic [4:0] c, output logic ie);
    int codes[$];
    bit irqs[$];
    if (bus.mie_in && m_eip()) begin codes.push_back(11); irqs.push_back(1); end
    if (bus.mie_in && m_sip()) begin codes.push_back(3);  irqs.push_back(1); end
    if (bus.mie_in && m_tip()) begin codes.push_back(7);  irqs.push_back(1); end
    for (int i = 0; i < NL; i++)
      if (bus.mie_in && bus.mlie_in[i] && bus.local_irq_in[i]) begin codes.push_back(16 + i); irqs.push_back(1); end
    if (bus.misaligned_instr_in) begin codes.push_back(0);  irqs.push_back(0); end
    if (bus.illegal_instr_in)    begin codes.push_back(2);  irqs.push_back(0); end
    if (cur_kind == K_EBREAK)    begin codes.push_back(3);  irqs.push_back(0); end
    if (cur_kind == K_ECALL)     begin codes.push_back(11); irqs.push_back(0); end
    if (bus.misaligned_store_in) begin codes.push_back(6);  irqs.push_back(0); end
    if (bus.misaligned_load_in)  begin codes.push_back(4);  irqs.push_back(0); end
    c  = 5'(codes[0]);
    ie = irqs[0];
  endtask

  task automatic m_step(logic rst_v);
    bit t;
    bit ipv;
    if (!rst_v) begin
      ph = M_BOOT; m_cause = '0; m_ie = 1'b0; m_mis = 1'b0; m_sleep = 0;
      return;
    end
    t   = m_trap();
    ipv = m_ip();
    m_mis = bus.misaligned_instr_in || bus.misaligned_load_in || bus.misaligned_store_in;
    if (t) m_cause_calc(m_cause, m_ie);
    case (ph)
      M_BOOT: ph = M_RUN;
      M_RUN: begin
        if (t)                      ph = M_ENTER;
        else if (cur_kind == K_MRET) ph = M_RET;
        else if (cur_kind == K_WFI) begin ph = M_SLEEP; m_sleep = 0; end
      end
      M_ENTER, M_RET: ph = M_RUN;
      M_SLEEP: begin
        if (bus.mie_in && ipv)                   ph = M_ENTER;
        else if (ipv || m_sleep == int'(TO) - 1) ph = M_RUN;
        else                                     m_sleep++;
      end
      default: ph = M_BOOT;
    endcase
  endtask

  function automatic logic [8:0] m_outs(mphase_t p);
    case (p)
      M_RUN:   return O_RUN;
      M_ENTER: return O_ENTER;
      M_RET:   return O_RET;
      M_SLEEP: return O_SLEEP;
      default: return O_BOOT;
    endcase
  endfunction

  task automatic drive_random();
    int r;
    r = $urandom_range(0, 15);
    if (r < 8)       set_instr(K_ADD);
    else if (r < 10) set_instr(K_NONE);
    else if (r == 10) set_instr(K_ECALL);
    else if (r == 11) set_instr(K_EBREAK);
    else if (r == 12) set_instr(K_MRET);
    else if (r < 15) set_instr(K_WFI);
    else             set_instr(K_NEAR);
    bus.mie_in  = 1'($urandom_range(0, 1));
    bus.meie_in = 1'($urandom_range(0, 1));
    bus.mtie_in = 1'($urandom_range(0, 1));
    bus.msie_in = 1'($urandom_range(0, 1));
    bus.e_irq_in = ($urandom_range(0, 15) == 0); bus.meip_in = ($urandom_range(0, 31) == 0);
    bus.t_irq_in = ($urandom_range(0, 15) == 0); bus.mtip_in = ($urandom_range(0, 31) == 0);
    bus.s_irq_in = ($urandom_range(0, 15) == 0); bus.msip_in = ($urandom_range(0, 31) == 0);
    bus.mlie_in = 4'($urandom);
    for (int i = 0; i < NL; i++) bus.local_irq_in[i] = ($urandom_range(0, 15) == 0);
    bus.illegal_instr_in    = ($urandom_range(0, 31) == 0);
    bus.misaligned_instr_in = ($urandom_range(0, 31) == 0);
    bus.misaligned_load_in  = ($urandom_range(0, 31) == 0);
    bus.misaligned_store_in = ($urandom_range(0, 31) == 0);
    bus.mtvec_mode_in = 1'($urandom_range(0, 1));
    rst_n = ($urandom_range(0, 39) != 0);
  endtask

  initial begin
    int cnt;
    clear_inputs();

    // ---------------- vector table ----------------
    add_vec("ext_vs_illegal",   K_NONE,   7'b1110000, 4'b0000, 4'b0000, 5'b10000, 1, 2'b10, 0, 11, 1, 0);
    add_vec("local_vectored",   K_NONE,   7'b1000000, 4'b0110, 4'b0110, 5'b00001, 1, 2'b10, 0, 17, 1, 68);
    add_vec("ecall_vec_exc",    K_ECALL,  7'b0000000, 4'b0000, 4'b0000, 5'b00001, 1, 2'b10, 0, 11, 0, 0);
    add_vec("ebreak",           K_EBREAK, 7'b0000000, 4'b0000, 4'b0000, 5'b00000, 1, 2'b10, 0, 3,  0, 0);
    add_vec("mret_trap_wins",   K_MRET,   7'b0000000, 4'b0000, 4'b0000, 5'b10000, 1, 2'b10, 0, 2,  0, 0);
    add_vec("mret",             K_MRET,   7'b0000000, 4'b0000, 4'b0000, 5'b00000, 0, 2'b01, 0, 0,  0, 0);
    add_vec("wfi_enter",        K_WFI,    7'b0000000, 4'b0000, 4'b0000, 5'b00000, 0, 2'b11, 1, 0,  0, 0);
    add_vec("masked_eip_store", K_NONE,   7'b0110000, 4'b0000, 4'b0000, 5'b00010, 1, 2'b10, 0, 6,  0, 0);
    add_vec("store_over_load",  K_NONE,   7'b0000000, 4'b0000, 4'b0000, 5'b00110, 1, 2'b10, 0, 6,  0, 0);
    add_vec("load_only",        K_NONE,   7'b0000000, 4'b0000, 4'b0000, 5'b00100, 1, 2'b10, 0, 4,  0, 0);
    add_vec("minstr_over_ill",  K_NONE,   7'b0000000, 4'b0000, 4'b0000, 5'b11000, 1, 2'b10, 0, 0,  0, 0);
    add_vec("sip_over_tip",     K_NONE,   7'b1001111, 4'b0000, 4'b0000, 5'b00001, 1, 2'b10, 0, 3,  1, 12);
    add_vec("tip_vectored",     K_NONE,   7'b1001100, 4'b0000, 4'b0000, 5'b00001, 1, 2'b10, 0, 7,  1, 28);
    add_vec("add_idle",         K_ADD,    7'b0000000, 4'b0000, 4'b0000, 5'b00000, 0, 2'b11, 0, 0,  0, 0);
    add_vec("meie_off",         K_NONE,   7'b1010000, 4'b0000, 4'b0000, 5'b00000, 0, 2'b11, 0, 0,  0, 0);
    add_vec("near_ecall_rd",    K_NEAR,   7'b0000000, 4'b0000, 4'b0000, 5'b00000, 0, 2'b11, 0, 0,  0, 0);
    add_vec("ecall_over_store", K_ECALL,  7'b0000000, 4'b0000, 4'b0000, 5'b00010, 1, 2'b10, 0, 11, 0, 0);
    add_vec("lowest_local",     K_NONE,   7'b1000000, 4'b1111, 4'b1010, 5'b00000, 1, 2'b10, 0, 17, 1, 0);
    add_vec("eip_over_local",   K_NONE,   7'b1110000, 4'b1111, 4'b1111, 5'b00001, 1, 2'b10, 0, 11, 1, 44);

    foreach (tbl[i]) begin
      do_reset();
      @(negedge clk);
      apply_vec(tbl[i]);
      #1 chk({tbl[i].name, "_trap"}, 32'(bus.trap_taken_out), 32'(tbl[i].exp_trap));
      @(posedge clk);
      @(negedge clk);
      chk({tbl[i].name, "_pc"},    32'(bus.pc_src_out), 32'(tbl[i].exp_pc));
      chk({tbl[i].name, "_stall"}, 32'(bus.stall_out),  32'(tbl[i].exp_stall));
      chk({tbl[i].name, "_cause"}, 32'(bus.cause_out),  32'(tbl[i].exp_cause));
      chk({tbl[i].name, "_ie"},    32'(bus.i_or_e_out), 32'(tbl[i].exp_ie));
      chk({tbl[i].name, "_off"},   32'(bus.trap_offset_out), 32'(tbl[i].exp_off));
      clear_inputs();
    end

    // ---------------- reset hold and release ----------------
    @(negedge clk); rst_n = 1'b0; clear_inputs(); bus.misaligned_load_in = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_outs",  32'(dut_outs()), 32'(O_BOOT));
    chk("rst_cause", 32'(bus.cause_out), 0);
    chk("rst_ie",    32'(bus.i_or_e_out), 0);
    chk("rst_mis",   32'(bus.misaligned_exception_out), 0);
    chk("rst_trap",  32'(bus.trap_taken_out), 0);
    rst_n = 1'b1; clear_inputs();
    @(posedge clk); @(negedge clk);
    chk("rel_outs", 32'(dut_outs()), 32'(O_RUN));

    // ---------------- ecall then mret ----------------
    set_instr(K_ECALL);
    @(posedge clk); @(negedge clk);
    chk("ecall_outs",  32'(dut_outs()), 32'(O_ENTER));
    chk("ecall_cause", 32'(bus.cause_out), 11);
    chk("ecall_ie",    32'(bus.i_or_e_out), 0);
    set_instr(K_MRET);
    @(posedge clk); @(negedge clk);
    chk("post_trap_outs", 32'(dut_outs()), 32'(O_RUN));
    @(posedge clk); @(negedge clk);
    chk("mret_outs", 32'(dut_outs()), 32'(O_RET));
    set_instr(K_NONE);
    @(posedge clk); @(negedge clk);
    chk("mret_back", 32'(dut_outs()), 32'(O_RUN));

    // ---------------- WFI timeout ----------------
    set_instr(K_WFI);
    @(posedge clk); @(negedge clk);
    set_instr(K_NONE);
    cnt = 0;
    while (bus.stall_out === 1'b1 && cnt < 30) begin
      cnt++;
      @(posedge clk); @(negedge clk);
    end
    chk("wfi_timeout_len", cnt, TO);
    chk("wfi_timeout_outs", 32'(dut_outs()), 32'(O_RUN));

    // ---------------- WFI woken by timer ----------------
    bus.mie_in = 1'b1; bus.mtie_in = 1'b1;
    set_instr(K_WFI);
    @(posedge clk); @(negedge clk);
    set_instr(K_NONE);
    for (int k = 0; k < 3; k++) begin
      chk("wfi_wait_outs", 32'(dut_outs()), 32'(O_SLEEP));
      @(posedge clk); @(negedge clk);
    end
    bus.mtip_in = 1'b1;
    #1 chk("wfi_wake_trap", 32'(bus.trap_taken_out), 1);
    @(posedge clk); @(negedge clk);
    chk("wfi_wake_outs",  32'(dut_outs()), 32'(O_ENTER));
    chk("wfi_wake_cause", 32'(bus.cause_out), 7);
    chk("wfi_wake_ie",    32'(bus.i_or_e_out), 1);
    clear_inputs();
    @(posedge clk); @(negedge clk);

    // ---------------- WFI resume without trap ----------------
    bus.msie_in = 1'b1; bus.msip_in = 1'b1;
    set_instr(K_WFI);
    #1 chk("wfi_nomie_trap0", 32'(bus.trap_taken_out), 0);
    @(posedge clk); @(negedge clk);
    set_instr(K_NONE);
    chk("wfi_nomie_sleep", 32'(dut_outs()), 32'(O_SLEEP));
    chk("wfi_nomie_trap1", 32'(bus.trap_taken_out), 0);
    @(posedge clk); @(negedge clk);
    chk("wfi_nomie_resume", 32'(dut_outs()), 32'(O_RUN));
    clear_inputs();

    // ---------------- randomized against model ----------------
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); m_step(rst_n);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      chk("rnd_outs",  32'(dut_outs()), 32'(m_outs(ph)));
      chk("rnd_cause", 32'(bus.cause_out), 32'(m_cause));
      chk("rnd_ie",    32'(bus.i_or_e_out), 32'(m_ie));
      chk("rnd_mis",   32'(bus.misaligned_exception_out), 32'(m_mis));
      drive_random();
      #1;
      chk("rnd_trap", 32'(bus.trap_taken_out), 32'(m_trap()));
      chk("rnd_off",  32'(bus.trap_offset_out),
          (bus.mtvec_mode_in && m_ie) ? 32'({m_cause, 2'b00}) : 32'd0);
      @(posedge clk);
      m_step(rst_n);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
